// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C target register block.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Open-drain I2C bus seen by the target: sampled SCL/SDA in, SDA drive pair out.
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic sda_t;

  modport master (output scl_i, output sda_i, input sda_o, input sda_t);
  modport slave  (input scl_i, input sda_i, output sda_o, output sda_t);
endinterface

// File: rtl/i2c_target_regs_line_cond.sv
// Per-line conditioning: 2-flop synchronizer, optional 3-sample majority
// filter (I2C_TARGET_GLITCH_FILTER_EN), then level/rise/fall detection.
module i2c_line_cond (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level,
  output logic rise,
  output logic fall
);
  logic sync1_q, sync2_q, prev_q, cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic hist0_q, hist1_q, filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_q <= 1'b1;
      hist1_q <= 1'b1;
      filt_q  <= 1'b1;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      filt_q  <= (sync2_q & hist0_q) | (sync2_q & hist1_q) | (hist0_q & hist1_q);
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= cond;
  end

  assign level = cond;
  assign rise  = cond & ~prev_q;
  assign fall  = ~cond & prev_q;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// Optional glitch filter on SCL/SDA: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PTR_W       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  i2c_target_regs_if.slave   bus,
  output logic               wr_valid,
  output logic [PTR_W-1:0]   wr_addr,
  output logic [7:0]         wr_data,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [7:0]         rd_data,
  output logic               busy
);
  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_cond u_scl (.clk(clk), .rst(rst), .line_i(bus.scl_i),
                       .level(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_cond u_sda (.clk(clk), .rst(rst), .line_i(bus.sda_i),
                       .level(sda), .rise(sda_rise), .fall(sda_fall));

  i2c_tgt_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic             sda_t_q, sda_t_d;
  logic             rack_q, rack_d;
  logic             wr_en;
  logic [7:0]       wr_byte;
  logic [7:0]       regs [DEPTH];

  assign ptr_inc = ptr_q + PTR_W'(1);
  assign wr_byte = {sh_q[6:0], sda};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    sda_t_d = sda_t_q;
    rack_d  = rack_q;
    wr_en   = 1'b0;
    if (scl && sda_fall) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      sda_t_d = 1'b1;
    end else if (scl && sda_rise) begin
      state_d = ST_IDLE;
      sda_t_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = wr_byte;
            cnt_d = cnt_q + 4'd1;
            wr_en = (state_q == ST_WDATA) && (cnt_q == 4'd7);
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_t_d = I2C_ACK;
            if (state_q == ST_ADDR) begin
              if (sh_q[7:1] == TARGET_ADDR) begin
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IGNORE;
                sda_t_d = 1'b1;
              end
            end else if (state_q == ST_PTR) begin
              state_d = ST_PTR_ACK;
              ptr_d   = sh_q[PTR_W-1:0];
            end else begin
              state_d = ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (sh_q[0]) begin
              state_d         = ST_RDATA;
              {sda_t_d, sh_d} = {regs[ptr_q], 1'b0};
            end else begin
              state_d = ST_PTR;
              sda_t_d = 1'b1;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = ST_WDATA;
            cnt_d   = '0;
            sda_t_d = 1'b1;
            if (state_q == ST_WDATA_ACK) ptr_d = ptr_inc;
          end
        end
        ST_RDATA: begin
          // MSB already on the wire; each fall shifts the next bit out.
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = ST_RACK;
              sda_t_d = 1'b1;
            end else begin
              {sda_t_d, sh_d} = {sh_q, 1'b0};
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            rack_d = sda;
          end else if (scl_fall) begin
            ptr_d = ptr_inc;
            if (rack_q == I2C_ACK) begin
              state_d         = ST_RDATA;
              cnt_d           = '0;
              {sda_t_d, sh_d} = {regs[ptr_inc], 1'b0};
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      sda_t_q  <= 1'b1;
      rack_q   <= I2C_NACK;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      sda_t_q  <= sda_t_d;
      rack_q   <= rack_d;
      wr_valid <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr_q;
        wr_data <= wr_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ptr_q] <= wr_byte;
    end
  end

  assign rd_data   = regs[rd_addr];
  assign busy      = (state_q != ST_IDLE);
  assign bus.sda_o = 1'b0;
  assign bus.sda_t = sda_t_q;
endmodule
